fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter XLEN, default 32, address/instruction width.
REQ-003 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  instruction word returned; in order, >= 1 cycle after request.
REQ-010 imem_rsp_data  input  XLEN  returned instruction word.
REQ-011 ins_valid  output  1  head entry available to decode stage.
REQ-012 ins_ready  input  1  decode accepts head entry (low = decode stall).
REQ-013 ins_data  output  XLEN  head instruction.
REQ-014 ins_pc  output  XLEN  address of head instruction.
REQ-015 redirect_valid  input  1  branch/jump resolved; discard all fetched and in-flight work.
REQ-016 redirect_pc  input  XLEN  new fetch address.

Function
REQ-017 fetch_pc register drives imem_req_addr; a request handshake (valid & ready) advances fetch_pc by 4, wrapping modulo 2^XLEN.
REQ-018 imem_req_valid = (count + outstanding < DEPTH) & ~redirect_valid; credit rule guarantees every response has a free slot.
REQ-019 outstanding counts accepted requests without responses; +1 on request handshake, -1 on response, both in one cycle = unchanged.
REQ-020 rsp_pc register tags responses: pushed entry = {rsp_pc, imem_rsp_data}, then rsp_pc += 4.
REQ-021 drop_cnt > 0 on a response: response discarded, drop_cnt -1, outstanding -1, no push, rsp_pc unchanged.
REQ-022 Queue is FIFO; ins_valid = (count != 0); ins_data/ins_pc = head entry; pop on ins_valid & ins_ready.
REQ-023 No bypass: a response pushed in cycle N is visible on ins_valid in cycle N+1 at earliest.
REQ-024 Simultaneous push and pop: count unchanged, both take effect, legal also when count = DEPTH-1 or DEPTH.
REQ-025 Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits; overflow/underflow unreachable; simulation assertion fires if violated.
REQ-026 redirect_valid has priority over everything in that cycle: queue emptied (count=0, pointers reset), pop ignored, same-cycle response discarded, no request issued.
REQ-027 On redirect: fetch_pc = rsp_pc = redirect_pc; drop_cnt = outstanding - (imem_rsp_valid ? 1 : 0); outstanding = drop_cnt.
REQ-028 Back-to-back redirects: the later one wins; drop_cnt recomputed per REQ-027 each time.
REQ-029 Request issue resumes the cycle after redirect; fresh responses are pushed only after drop_cnt reaches 0.
REQ-030 ins_ready low holds head entry and outputs stable; requests continue until credits run out.

Reset
REQ-031 On reset: fetch_pc = rsp_pc = RESET_PC, count = outstanding = drop_cnt = 0, pointers 0, ins_valid = 0, imem_req_valid = 0.
REQ-032 Reset mid-operation abandons in-flight requests; memory is reset by the same signal, so no drop is required.
REQ-033 First request issues in the first cycle after reset deassertion, with address RESET_PC.

Structure
REQ-034 Shared package mips_pkg holds XLEN, RESET_PC default, PC_STEP = 4 and the fetch_entry_t {pc, ins} type.
REQ-035 Storage and pointers live in one sub-module fetch_fifo (DEPTH, entry width); credit, drop and PC logic stay in fetch_buffer.

Verification
REQ-036 Reset, memory ready, 1-cycle response, ins_ready=1 -> ins_pc 0x3000, 0x3004, 0x3008 on consecutive cycles after a 2-cycle fill.
REQ-037 ins_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0, ins_pc held at 0x3000.
REQ-038 3 requests outstanding, redirect_pc=0x3400 -> the 3 stale responses are discarded, next ins_pc = 0x3400.
REQ-039 Redirect in the same cycle as a response and a pop -> response dropped, drop_cnt = outstanding-1, queue empty next cycle.
REQ-040 Redirects in 2 consecutive cycles to 0x3100 then 0x3200 -> first delivered ins_pc = 0x3200.
REQ-041 Reset asserted while queue is full -> ins_valid=0 immediately, first request after release at 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared front-end definitions: datapath width, reset fetch address and the
// fetch queue entry layout.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // One decoded-stage candidate: the instruction word tagged with its address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: a DEPTH-entry FIFO with a flush that empties it in one
// cycle. The head entry comes straight from storage, so there is no bypass.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any push or pop presented in the same cycle.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // At full, a simultaneous pop frees the very slot the push lands in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(do_push && !do_pop && count == CNT_W'(DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(do_pop && count == '0));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches under a credit limit,
// queues returned words for decode and discards stale work on a redirect.
module fetch_buffer #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = mips_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [XLEN-1:0] ins_data,
    output logic [XLEN-1:0] ins_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import mips_pkg::*;

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  fetch_pc_nxt;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  rsp_pc_nxt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] rsp_dec;

    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_push;
    logic             ins_pop;

    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Queued entries plus in-flight requests never exceed DEPTH, so every
    // response is guaranteed a slot.
    assign credit_ok      = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
    assign imem_req_valid = credit_ok & ~redirect_valid & ~reset;
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_push = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign ins_pop  = ins_valid & ins_ready & ~redirect_valid;
    assign rsp_dec  = CNT_W'(imem_rsp_valid);

    // Fetch/response PC, credit and drop bookkeeping; redirect overrides all.
    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        rsp_pc_nxt      = rsp_pc;
        outstanding_nxt = outstanding;
        drop_cnt_nxt    = drop_cnt;

        if (redirect_valid) begin
            fetch_pc_nxt    = redirect_pc;
            rsp_pc_nxt      = redirect_pc;
            outstanding_nxt = outstanding - rsp_dec;
            drop_cnt_nxt    = outstanding - rsp_dec;
        end else begin
            if (req_fire) begin
                fetch_pc_nxt = fetch_pc + XLEN'(PC_STEP);
            end
            if (rsp_push) begin
                rsp_pc_nxt = rsp_pc + XLEN'(PC_STEP);
            end
            if (rsp_drop) begin
                drop_cnt_nxt = drop_cnt - CNT_W'(1);
            end
            outstanding_nxt = outstanding + CNT_W'(req_fire) - rsp_dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            rsp_pc      <= rsp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

    // Entry layout follows the shared package; XLEN is expected to match it.
    always_comb begin
        push_entry     = '0;
        push_entry.pc  = rsp_pc;
        push_entry.ins = imem_rsp_data;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (ins_pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign ins_valid = (count != '0);
    assign ins_data  = head_entry.ins;
    assign ins_pc    = head_entry.pc;

    a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && outstanding == '0));

endmodule
